fact_judge: RTL and testbench

Answer-side consumer of the 24-bit factorization question word produced by the question database. It captures the question one cycle after the shared `OK` strobe, decodes and self-checks it, collects up to three prime-code key entries from the player, and judges the entry against the problem number by product comparison. It sits between the question database and the display/score logic.

---
 rtl/fact_judge_if.sv | 29 ++
 rtl/fact_judge.sv | 181 ++++++++++++++++++
 tb/tb_fact_judge.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fact_judge_if.sv
// Question/answer bus between the question database, key pad and fact_judge.
// The database side drives the question and the strobes; the judge drives back
// the latched display digits, entry count and result flags.
interface fact_judge_if;
    logic        OK;
    logic [23:0] QUESTION;
    logic        KEY_VALID;
    logic [3:0]  KEY_CODE;
    logic        ENTER;
    logic        CLR;
    logic [3:0]  DISP2;
    logic [3:0]  DISP1;
    logic [3:0]  DISP0;
    logic [1:0]  ENTRY_CNT;
    logic        BUSY;
    logic        CORRECT;
    logic        WRONG;
    logic        Q_ERR;

    modport master (
        output OK, QUESTION, KEY_VALID, KEY_CODE, ENTER, CLR,
        input  DISP2, DISP1, DISP0, ENTRY_CNT, BUSY, CORRECT, WRONG, Q_ERR
    );

    modport slave (
        input  OK, QUESTION, KEY_VALID, KEY_CODE, ENTER, CLR,
        output DISP2, DISP1, DISP0, ENTRY_CNT, BUSY, CORRECT, WRONG, Q_ERR
    );
endinterface

// File: rtl/fact_judge.sv
// Factorization judge: latches a question word, self-checks it by multiplying
// its answer primes back against the BCD problem number, then collects up to
// three player prime codes and judges them by the same product comparison.
// One shared 14-bit product register and multiplier serve both phases.
module fact_judge (
    input  logic        CLK,
    input  logic        RST,
    fact_judge_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] QCHK   = 3'd2;
    localparam logic [2:0] QCMP   = 3'd3;
    localparam logic [2:0] INPUT  = 3'd4;
    localparam logic [2:0] JUDGE  = 3'd5;
    localparam logic [2:0] JCMP   = 3'd6;
    localparam logic [2:0] RESULT = 3'd7;

    logic [2:0]  state;
    logic [23:0] q;          // latched question word; [23:12] doubles as DISPx
    logic [9:0]  target;
    logic [13:0] product;    // 23^3 = 12167 fits in 14 bits
    logic [1:0]  idx;        // which factor the multiplier consumes this cycle
    logic [3:0]  slot0, slot1, slot2;
    logic [1:0]  cnt;
    logic        busy, correct, wrong, q_err;

    logic [3:0]  fac_code;
    logic [13:0] product_nxt;
    logic [9:0]  target_nxt;
    logic        q_bad;
    logic        key_ok;

    // Code 0 (empty) and the invalid codes 10..15 act as factor 1; invalid
    // question codes are rejected separately, invalid keys never get stored.
    function automatic logic [4:0] prime_of(input logic [3:0] code);
        case (code)
            4'd1:    prime_of = 5'd2;
            4'd2:    prime_of = 5'd3;
            4'd3:    prime_of = 5'd5;
            4'd4:    prime_of = 5'd7;
            4'd5:    prime_of = 5'd11;
            4'd6:    prime_of = 5'd13;
            4'd7:    prime_of = 5'd17;
            4'd8:    prime_of = 5'd19;
            4'd9:    prime_of = 5'd23;
            default: prime_of = 5'd1;
        endcase
    endfunction

    // Factor select: answer nibbles while checking the question, slots while judging.
    always_comb begin
        fac_code = 4'd0;
        if (state == QCHK) begin
            case (idx)
                2'd0:    fac_code = q[11:8];
                2'd1:    fac_code = q[7:4];
                default: fac_code = q[3:0];
            endcase
        end else begin
            case (idx)
                2'd0:    fac_code = slot0;
                2'd1:    fac_code = slot1;
                default: fac_code = slot2;
            endcase
        end
    end

    assign product_nxt = product * {9'd0, prime_of(fac_code)};
    assign target_nxt  = ({6'd0, bus.QUESTION[23:20]} * 10'd100)
                       + ({6'd0, bus.QUESTION[19:16]} * 10'd10)
                       +  {6'd0, bus.QUESTION[15:12]};

    assign q_bad = (q[23:20] > 4'd9) || (q[19:16] > 4'd9) || (q[15:12] > 4'd9)
                || (q[11:8]  > 4'd9) || (q[7:4]   > 4'd9) || (q[3:0]   > 4'd9)
                || (product != {4'd0, target});

    assign key_ok = bus.KEY_VALID && (bus.KEY_CODE != 4'd0)
                 && (bus.KEY_CODE <= 4'd9) && (cnt != 2'd3);

    // Main sequencer: load, self-check, entry collection and judging.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            q       <= 24'd0;
            target  <= 10'd0;
            product <= 14'd0;
            idx     <= 2'd0;
            slot0   <= 4'd0;
            slot1   <= 4'd0;
            slot2   <= 4'd0;
            cnt     <= 2'd0;
            busy    <= 1'b0;
            correct <= 1'b0;
            wrong   <= 1'b0;
            q_err   <= 1'b0;
        end else begin
            case (state)
                IDLE, RESULT: begin
                    if (bus.OK) state <= LOAD;
                end
                INPUT: begin
                    // OK > CLR > ENTER > KEY_VALID; losers are dropped
                    if (bus.OK) begin
                        state <= LOAD;
                    end else if (bus.CLR) begin
                        slot0 <= 4'd0;
                        slot1 <= 4'd0;
                        slot2 <= 4'd0;
                        cnt   <= 2'd0;
                    end else if (bus.ENTER) begin
                        if (cnt != 2'd0) begin
                            product <= 14'd1;
                            idx     <= 2'd0;
                            busy    <= 1'b1;
                            state   <= JUDGE;
                        end
                    end else if (key_ok) begin
                        case (cnt)
                            2'd0:    slot0 <= bus.KEY_CODE;
                            2'd1:    slot1 <= bus.KEY_CODE;
                            default: slot2 <= bus.KEY_CODE;
                        endcase
                        cnt <= cnt + 2'd1;
                    end
                end
                LOAD: begin
                    q       <= bus.QUESTION;
                    target  <= target_nxt;
                    slot0   <= 4'd0;
                    slot1   <= 4'd0;
                    slot2   <= 4'd0;
                    cnt     <= 2'd0;
                    correct <= 1'b0;
                    wrong   <= 1'b0;
                    q_err   <= 1'b0;
                    product <= 14'd1;
                    idx     <= 2'd0;
                    busy    <= 1'b1;
                    state   <= QCHK;
                end
                QCHK, JUDGE: begin
                    product <= product_nxt;
                    if (idx == 2'd2) begin
                        idx   <= 2'd0;
                        state <= (state == QCHK) ? QCMP : JCMP;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                QCMP: begin
                    busy <= 1'b0;
                    if (q_bad) begin
                        q_err <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= INPUT;
                    end
                end
                JCMP: begin
                    busy <= 1'b0;
                    if (product == {4'd0, target}) correct <= 1'b1;
                    else                           wrong   <= 1'b1;
                    state <= RESULT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DISP2     = q[23:20];
    assign bus.DISP1     = q[19:16];
    assign bus.DISP0     = q[15:12];
    assign bus.ENTRY_CNT = cnt;
    assign bus.BUSY      = busy;
    assign bus.CORRECT   = correct;
    assign bus.WRONG     = wrong;
    assign bus.Q_ERR     = q_err;

endmodule

// File: tb/tb_fact_judge.sv
// Directed bench for fact_judge: question load/self-check, entry collection,
// judging, strobe priority and asynchronous reset. Inputs change and outputs
// are sampled 1 ns after the rising edge.
module tb_fact_judge;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    fact_judge_if bus ();

    fact_judge dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Returns just after edge N (the edge that samples OK).
    task automatic pulse_ok(input logic [23:0] qw);
        bus.QUESTION = qw;
        bus.OK = 1'b1;
        cyc(1);
        bus.OK = 1'b0;
    endtask

    task automatic key(input logic [3:0] code);
        bus.KEY_CODE  = code;
        bus.KEY_VALID = 1'b1;
        cyc(1);
        bus.KEY_VALID = 1'b0;
    endtask

    // Returns just after edge M (the edge that samples ENTER).
    task automatic enter();
        bus.ENTER = 1'b1;
        cyc(1);
        bus.ENTER = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cyc(2);
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        checks++; if (bus.ENTRY_CNT !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.ENTRY_CNT); end
        checks++; if ({bus.CORRECT, bus.WRONG, bus.Q_ERR} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.CORRECT, bus.WRONG, bus.Q_ERR}); end
        checks++; if ({bus.DISP2, bus.DISP1, bus.DISP0} !== 12'h000) begin errors++; $display("FAIL reset_disp: got %h want 000", {bus.DISP2, bus.DISP1, bus.DISP0}); end
        RST = 1'b0;
        cyc(1);
    endtask

    task automatic test_correct();
        pulse_ok(24'h042124);
        cyc(1);
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL load_busy_n1: got %b want 1", bus.BUSY); end
        checks++; if ({bus.DISP2, bus.DISP1, bus.DISP0} !== 12'h042) begin errors++; $display("FAIL load_disp: got %h want 042", {bus.DISP2, bus.DISP1, bus.DISP0}); end
        cyc(3);
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL qchk_busy_n4: got %b want 1", bus.BUSY); end
        cyc(1);
        checks++; if ({bus.BUSY, bus.Q_ERR} !== 2'b00) begin errors++; $display("FAIL qcmp_n5: busy,qerr got %b want 00", {bus.BUSY, bus.Q_ERR}); end
        key(4'd4);
        checks++; if (bus.ENTRY_CNT !== 2'd1) begin errors++; $display("FAIL cnt_after_1key: got %0d want 1", bus.ENTRY_CNT); end
        key(4'd1);
        key(4'd2);
        checks++; if (bus.ENTRY_CNT !== 2'd3) begin errors++; $display("FAIL cnt_after_3key: got %0d want 3", bus.ENTRY_CNT); end
        enter();
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL judge_busy_m: got %b want 1", bus.BUSY); end
        cyc(3);
        checks++; if ({bus.BUSY, bus.CORRECT} !== 2'b10) begin errors++; $display("FAIL judge_m3: busy,correct got %b want 10", {bus.BUSY, bus.CORRECT}); end
        cyc(1);
        checks++; if ({bus.BUSY, bus.CORRECT, bus.WRONG} !== 3'b010) begin errors++; $display("FAIL judge_m4_correct: busy,correct,wrong got %b want 010", {bus.BUSY, bus.CORRECT, bus.WRONG}); end
    endtask

    task automatic test_wrong();
        pulse_ok(24'h027222);
        cyc(5);
        checks++; if (bus.Q_ERR !== 1'b0) begin errors++; $display("FAIL q27_qerr: got %b want 0", bus.Q_ERR); end
        key(4'd2);
        key(4'd2);
        enter();
        cyc(4);
        checks++; if ({bus.CORRECT, bus.WRONG} !== 2'b01) begin errors++; $display("FAIL wrong_m4: correct,wrong got %b want 01", {bus.CORRECT, bus.WRONG}); end
        pulse_ok(24'h027222);
        checks++; if (bus.WRONG !== 1'b1) begin errors++; $display("FAIL wrong_held_until_load: got %b want 1", bus.WRONG); end
        cyc(1);
        checks++; if (bus.WRONG !== 1'b0) begin errors++; $display("FAIL wrong_cleared_at_load: got %b want 0", bus.WRONG); end
        cyc(4);
        checks++; if ({bus.BUSY, bus.Q_ERR} !== 2'b00) begin errors++; $display("FAIL reload27_n5: busy,qerr got %b want 00", {bus.BUSY, bus.Q_ERR}); end
    endtask

    task automatic test_bad_question();
        // from INPUT: answer primes 2*3*5 = 30, problem 42
        pulse_ok(24'h042123);
        cyc(4);
        checks++; if (bus.Q_ERR !== 1'b0) begin errors++; $display("FAIL badprod_n4: got %b want 0", bus.Q_ERR); end
        cyc(1);
        checks++; if ({bus.BUSY, bus.Q_ERR} !== 2'b01) begin errors++; $display("FAIL badprod_n5: busy,qerr got %b want 01", {bus.BUSY, bus.Q_ERR}); end
        key(4'd4);
        checks++; if (bus.ENTRY_CNT !== 2'd0) begin errors++; $display("FAIL badprod_key_ignored: got %0d want 0", bus.ENTRY_CNT); end
        enter();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL badprod_enter_ignored: got %b want 0", bus.BUSY); end
        // from IDLE: tens digit 0xA
        pulse_ok(24'h0A2124);
        cyc(1);
        checks++; if ({bus.Q_ERR, bus.DISP1} !== 5'b0_1010) begin errors++; $display("FAIL badbcd_load: qerr,disp1 got %b want 01010", {bus.Q_ERR, bus.DISP1}); end
        cyc(4);
        checks++; if ({bus.BUSY, bus.Q_ERR} !== 2'b01) begin errors++; $display("FAIL badbcd_n5: busy,qerr got %b want 01", {bus.BUSY, bus.Q_ERR}); end
        key(4'd1);
        checks++; if (bus.ENTRY_CNT !== 2'd0) begin errors++; $display("FAIL badbcd_key_ignored: got %0d want 0", bus.ENTRY_CNT); end
    endtask

    task automatic test_entry_bounds();
        logic [1:0] exp_cnt [6];
        logic [3:0] codes   [6];
        codes   = '{4'd5, 4'd0, 4'd12, 4'd3, 4'd3, 4'd3};
        exp_cnt = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
        pulse_ok(24'h042124);
        cyc(5);
        for (int i = 0; i < 6; i++) begin
            key(codes[i]);
            checks++; if (bus.ENTRY_CNT !== exp_cnt[i]) begin errors++; $display("FAIL bounds_key%0d(code %0d): cnt got %0d want %0d", i, codes[i], bus.ENTRY_CNT, exp_cnt[i]); end
        end
        // slots 5,3,3 -> 11*5*5 = 275, not 42
        enter();
        cyc(4);
        checks++; if ({bus.CORRECT, bus.WRONG} !== 2'b01) begin errors++; $display("FAIL bounds_slots_judged: correct,wrong got %b want 01", {bus.CORRECT, bus.WRONG}); end
        pulse_ok(24'h042124);
        cyc(5);
        key(4'd4);
        bus.CLR = 1'b1;
        bus.KEY_VALID = 1'b1;
        bus.KEY_CODE = 4'd2;
        cyc(1);
        bus.CLR = 1'b0;
        bus.KEY_VALID = 1'b0;
        checks++; if (bus.ENTRY_CNT !== 2'd0) begin errors++; $display("FAIL clr_beats_key: cnt got %0d want 0", bus.ENTRY_CNT); end
        enter();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL enter_empty_busy: got %b want 0", bus.BUSY); end
        cyc(4);
        checks++; if ({bus.BUSY, bus.CORRECT, bus.WRONG} !== 3'b000) begin errors++; $display("FAIL enter_empty_noresult: busy,correct,wrong got %b want 000", {bus.BUSY, bus.CORRECT, bus.WRONG}); end
        key(4'd2);
        key(4'd1);
        key(4'd4);
        enter();
        cyc(4);
        checks++; if ({bus.CORRECT, bus.WRONG} !== 2'b10) begin errors++; $display("FAIL still_in_input: correct,wrong got %b want 10", {bus.CORRECT, bus.WRONG}); end
    endtask

    task automatic test_order_and_reload();
        pulse_ok(24'h030123);
        cyc(1);
        checks++; if (bus.CORRECT !== 1'b0) begin errors++; $display("FAIL correct_cleared_at_load: got %b want 0", bus.CORRECT); end
        cyc(4);
        key(4'd3);
        key(4'd1);
        key(4'd2);
        enter();
        cyc(4);
        checks++; if ({bus.CORRECT, bus.WRONG} !== 2'b10) begin errors++; $display("FAIL order_30: correct,wrong got %b want 10", {bus.CORRECT, bus.WRONG}); end
        pulse_ok(24'h030123);
        cyc(5);
        key(4'd3);
        key(4'd1);
        pulse_ok(24'h030123);
        checks++; if (bus.ENTRY_CNT !== 2'd2) begin errors++; $display("FAIL reload_cnt_before_load: got %0d want 2", bus.ENTRY_CNT); end
        cyc(1);
        checks++; if ({bus.BUSY, bus.ENTRY_CNT} !== 3'b1_00) begin errors++; $display("FAIL reload_discards: busy,cnt got %b want 100", {bus.BUSY, bus.ENTRY_CNT}); end
        cyc(4);
        checks++; if ({bus.BUSY, bus.Q_ERR} !== 2'b00) begin errors++; $display("FAIL reload_complete: busy,qerr got %b want 00", {bus.BUSY, bus.Q_ERR}); end
        key(4'd2);
        key(4'd3);
        key(4'd1);
        enter();
        cyc(4);
        checks++; if ({bus.CORRECT, bus.WRONG} !== 2'b10) begin errors++; $display("FAIL reload_judge: correct,wrong got %b want 10", {bus.CORRECT, bus.WRONG}); end
    endtask

    task automatic test_reset_mid_judge();
        pulse_ok(24'h042124);
        cyc(5);
        key(4'd4);
        key(4'd1);
        key(4'd2);
        enter();
        cyc(1);
        #2 RST = 1'b1;
        #1;
        checks++; if ({bus.BUSY, bus.CORRECT, bus.WRONG, bus.Q_ERR, bus.ENTRY_CNT} !== 6'd0) begin errors++; $display("FAIL async_reset_flags: busy,c,w,qerr,cnt got %b want 000000", {bus.BUSY, bus.CORRECT, bus.WRONG, bus.Q_ERR, bus.ENTRY_CNT}); end
        checks++; if ({bus.DISP2, bus.DISP1, bus.DISP0} !== 12'h000) begin errors++; $display("FAIL async_reset_disp: got %h want 000", {bus.DISP2, bus.DISP1, bus.DISP0}); end
        cyc(1);
        RST = 1'b0;
        cyc(4);
        checks++; if ({bus.BUSY, bus.CORRECT, bus.WRONG} !== 3'b000) begin errors++; $display("FAIL post_reset_idle: busy,c,w got %b want 000", {bus.BUSY, bus.CORRECT, bus.WRONG}); end
        pulse_ok(24'h042124);
        cyc(5);
        key(4'd2);
        key(4'd4);
        key(4'd1);
        enter();
        cyc(4);
        checks++; if ({bus.BUSY, bus.CORRECT, bus.WRONG} !== 3'b010) begin errors++; $display("FAIL post_reset_run: busy,c,w got %b want 010", {bus.BUSY, bus.CORRECT, bus.WRONG}); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        RST           = 1'b1;
        bus.OK        = 1'b0;
        bus.QUESTION  = 24'd0;
        bus.KEY_VALID = 1'b0;
        bus.KEY_CODE  = 4'd0;
        bus.ENTER     = 1'b0;
        bus.CLR       = 1'b0;
        #1;
        test_reset();
        test_correct();
        test_wrong();
        test_bad_question();
        test_entry_bounds();
        test_order_and_reload();
        test_reset_mid_judge();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
